game_soc_key_pio: RTL

- Parametrised Avalon-MM slave input PIO for push-buttons and switches in game_soc.
- Successor to the fixed 2-bit input port. Adds:
  - configurable width;
  - two-flop input synchroniser;
  - per-bit edge capture with selectable edge type;
  - interrupt mask and level IRQ to the Nios II;
  - optional per-bit debounce filter.

---
 rtl/game_soc_key_pio.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/game_soc_key_pio.sv
// Avalon-MM input PIO for game_soc keys/switches: synchroniser, edge capture, masked level IRQ.
// Optional per-bit debounce filter is enabled by defining GAME_SOC_KEY_PIO_DEBOUNCE_EN.
module game_soc_key_pio #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1, sync2, filtered, prev;
  logic [WIDTH-1:0] edgecapture, irqmask, edge_det, rise, fall, w1c;
  logic             prime_cnt, primed, prime_edge;
  logic             wr_en, rd_en;
  logic [31:0]      rd_mux;

  // Bus handshake: no wait states. A write lands on the clk edge where
  // chipselect & write is high; a read strobe (chipselect & read) returns
  // data on readdata exactly one clk later, and readdata is 0 otherwise.
  assign wr_en = chipselect & write;
  assign rd_en = chipselect & read;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt <= 1'b0;
      primed    <= 1'b0;
    end else begin
      prime_cnt <= 1'b1;
      primed    <= primed | prime_cnt;
    end
  end

  // The priming edge loads the value sync2 takes on that same edge, so a
  // key held through reset primes as its real level and never looks like an edge.
  assign prime_edge = prime_cnt & ~primed;

`ifdef GAME_SOC_KEY_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] filt_q;
  logic [CW-1:0]    db_cnt [WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else if (prime_edge) begin
      filt_q <= sync1;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else if (primed) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == filt_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          filt_q[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign filtered = filt_q;
`else
  assign filtered = primed ? sync2 : '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        prev <= '0;
    else if (prime_edge) prev <= sync1;
    else if (primed)     prev <= filtered;
  end

  assign rise = filtered & ~prev;
  assign fall = ~filtered & prev;

  always_comb begin
    edge_det = '0;
    if (primed) begin
      case (EDGE_TYPE)
        0:       edge_det = rise;
        1:       edge_det = fall;
        default: edge_det = rise | fall;
      endcase
    end
  end

  assign w1c = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // A new edge in the same cycle as its W1C clear keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
      irqmask     <= '0;
      irq         <= 1'b0;
    end else begin
      edgecapture <= (edgecapture & ~w1c) | edge_det;
      if (wr_en && address == 2'd1) irqmask <= writedata[WIDTH-1:0];
      irq <= |(edgecapture & irqmask);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = filtered;
      2'd1:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
    else            readdata <= '0;
  end

  generate
    if (WIDTH < 32) begin : g_wd_upper
      logic unused_wd_upper;
      assign unused_wd_upper = ^writedata[31:WIDTH];
    end
  endgenerate

endmodule
